// File: rtl/scan_chain_ctrl_if.sv
// Host-side request/response bundle for scan_chain_ctrl.
// Words are declared [0:WORD_LENGTH-1]; index 0 is the MSB.
interface scan_chain_ctrl_if #(
  parameter int WORD_LENGTH = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic [0:WORD_LENGTH-1] req_wdata;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [0:WORD_LENGTH-1] resp_rdata;
  logic                   resp_parity;

  modport master (
    output req_valid, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_parity
  );

  modport slave (
    input  req_valid, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_parity
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain initiator: capture pulse, WORD_LENGTH-bit serial exchange
// (LSB first), update pulse, then the collected word is returned to the host.
// Optional build macro: SCAN_PARITY_EN adds even parity of the returned word.
module scan_chain_ctrl #(
  parameter int WORD_LENGTH = 32,
  localparam int CNT_W = $clog2(WORD_LENGTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  scan_chain_ctrl_if.slave  bus,
  output logic              scan_en,
  output logic              scan_out,
  input  logic              scan_in,
  output logic              cap_en,
  output logic              upd_en
);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, RESP} state_t;

  state_t                 state;
  logic [0:WORD_LENGTH-1] sr;
  logic [0:WORD_LENGTH-1] rdata_q;
  logic [CNT_W-1:0]       cnt;
  logic                   req_ready_q;
  logic                   resp_valid_q;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;

  // Sequencer; every output is set up one edge ahead so it is a plain flop.
  // scan_out is preloaded with the bit that sits at the LSB after the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sr           <= '0;
      rdata_q      <= '0;
      cnt          <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      scan_en      <= 1'b0;
      scan_out     <= 1'b0;
      cap_en       <= 1'b0;
      upd_en       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            sr          <= bus.req_wdata;
            cnt         <= '0;
            req_ready_q <= 1'b0;
            cap_en      <= 1'b1;
            state       <= CAPTURE;
          end
        end
        CAPTURE: begin
          cap_en   <= 1'b0;
          scan_en  <= 1'b1;
          scan_out <= sr[WORD_LENGTH-1];
          state    <= SHIFT;
        end
        SHIFT: begin
          sr  <= {scan_in, sr[0:WORD_LENGTH-2]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WORD_LENGTH-1)) begin
            scan_en  <= 1'b0;
            scan_out <= 1'b0;
            upd_en   <= 1'b1;
            state    <= UPDATE;
          end else begin
            scan_out <= sr[WORD_LENGTH-2];
          end
        end
        UPDATE: begin
          upd_en       <= 1'b0;
          resp_valid_q <= 1'b1;
          rdata_q      <= sr;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_PARITY_EN
  logic par_q;

  // Parity of the final shift word, latched alongside rdata and dropped on return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                par_q <= 1'b0;
    else if (state == UPDATE)                par_q <= ^sr;
    else if (state == RESP && bus.resp_ready) par_q <= 1'b0;
  end

  assign bus.resp_parity = par_q;
`else
  assign bus.resp_parity = 1'b0;
`endif

endmodule
